// File: rtl/twiddle_gen_sdf_if.sv
// Sample-in / twiddle-out bundle for the SDF stage twiddle generator.
// The generator sits on the slave side; the sample source and multiplier sit on the master side.
interface twiddle_gen_sdf_if #(
    parameter int unsigned DATA_WIDTH = 15,
    parameter int unsigned EXP_WIDTH  = 6
);
    logic                         in_valid;
    logic                         frame_start;
    logic signed [DATA_WIDTH-1:0] tw_real;
    logic signed [DATA_WIDTH-1:0] tw_imag;
    logic                         tw_trivial;
    logic [EXP_WIDTH-1:0]         tw_exp;
    logic                         out_valid;
    logic                         frame_done;

    modport master (
        output in_valid,
        output frame_start,
        input  tw_real,
        input  tw_imag,
        input  tw_trivial,
        input  tw_exp,
        input  out_valid,
        input  frame_done
    );

    modport slave (
        input  in_valid,
        input  frame_start,
        output tw_real,
        output tw_imag,
        output tw_trivial,
        output tw_exp,
        output out_valid,
        output frame_done
    );
endinterface

// File: rtl/twiddle_gen_sdf.sv
// Streaming twiddle-factor generator for one SDF FFT stage.
// Counts accepted samples, derives the stage exponent (radix-2 or radix-2^2 DIF schedule) and
// expands a quarter-wave cos/-sin table by quadrant symmetry. Two-cycle fixed latency.
module twiddle_gen_sdf #(
    parameter int unsigned NFFT       = 64,
    parameter int unsigned DATA_WIDTH = 15,
    parameter int unsigned FRAC_BITS  = 10,
    parameter int unsigned STAGE      = 0,
    parameter int unsigned MODE       = 0
) (
    input logic              clk,
    input logic              rst_n,
    twiddle_gen_sdf_if.slave tw_if
);
    localparam int unsigned Log2N   = $clog2(NFFT);
    localparam int unsigned Quarter = NFFT / 4;
    localparam int unsigned RBits   = Log2N - 2;
    localparam int unsigned RomBits = Quarter * DATA_WIDTH;
    localparam real         Pi      = 3.14159265358979323846;

    // Taylor series; argument never exceeds pi/2, so 12 terms are far below one LSB of error.
    function automatic real cos_t(input real x);
        real term;
        real sum;
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / (real'(2 * n - 1) * real'(2 * n));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic real sin_t(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Round half away from zero.
    function automatic int round_r(input real x);
        if (x >= 0.0) begin
            return $rtoi(x + 0.5);
        end
        return -$rtoi(0.5 - x);
    endfunction

    // Quarter-wave table packed into one vector: entry k = round(2^FRAC_BITS * cos or -sin).
    function automatic logic [RomBits-1:0] build_rom(input logic imag_part);
        logic [RomBits-1:0] rom;
        real                x;
        real                val;
        rom = '0;
        for (int k = 0; k < int'(Quarter); k++) begin
            x   = 2.0 * Pi * real'(k) / real'(NFFT);
            val = imag_part ? -sin_t(x) : cos_t(x);
            rom[k*DATA_WIDTH +: DATA_WIDTH] =
                DATA_WIDTH'(round_r(val * real'(1 << FRAC_BITS)));
        end
        return rom;
    endfunction

    localparam logic [RomBits-1:0] RomRe = build_rom(1'b0);
    localparam logic [RomBits-1:0] RomIm = build_rom(1'b1);

    logic [Log2N-1:0]             c_q, c_d, ci;
    logic [Log2N-1:0]             e_d, e_q;
    logic                         v1_q, v1_d;
    logic                         last1_q, last1_d;
    logic [RBits-1:0]             r_d;
    logic signed [DATA_WIDTH-1:0] rom_re_q, rom_re_d, rom_im_q, rom_im_d;
    logic [1:0]                   qd;
    logic signed [DATA_WIDTH-1:0] map_re, map_im;
    logic signed [DATA_WIDTH-1:0] tw_real_q, tw_real_d, tw_imag_q, tw_imag_d;
    logic [Log2N-1:0]             tw_exp_q, tw_exp_d;
    logic                         tw_trivial_q, tw_trivial_d;
    logic                         out_valid_q, out_valid_d;
    logic                         frame_done_q, frame_done_d;

    if (MODE == 0) begin : g_radix2
        // Stage m: upper half of each L-point block gets e = (ci mod L/2) * 2^m.
        localparam int unsigned    LogL  = Log2N - STAGE;
        localparam logic [Log2N-1:0] JMask = Log2N'((1 << (LogL - 1)) - 1);

        // Radix-2 exponent of the current effective index
        always_comb begin
            e_d = ci[LogL-1] ? ((ci & JMask) << STAGE) : '0;
        end
    end else begin : g_radix22
        // Stage pair p: e = n1 * bitrev2(q) * 4^p, q selecting the quarter of the L-point block.
        localparam int unsigned      LogL   = Log2N - 2 * STAGE;
        localparam logic [Log2N-1:0] N1Mask = Log2N'((1 << (LogL - 2)) - 1);

        logic [1:0]       q;
        logic [Log2N-1:0] br;
        logic [Log2N-1:0] prod;

        // Radix-2^2 exponent; truncation to Log2N bits is the mod NFFT
        always_comb begin
            q    = ci[LogL-1 -: 2];
            br   = {{(Log2N - 2){1'b0}}, q[0], q[1]};
            prod = (ci & N1Mask) * br;
            e_d  = prod << (2 * STAGE);
        end
    end

    // Sample counter next state and stage-1 inputs, including the table lookup
    always_comb begin
        ci       = tw_if.frame_start ? '0 : c_q;
        c_d      = tw_if.in_valid ? ci + 1'b1 : c_q;
        v1_d     = tw_if.in_valid;
        last1_d  = (ci == Log2N'(NFFT - 1));
        r_d      = e_d[RBits-1:0];
        rom_re_d = RomRe[r_d*DATA_WIDTH +: DATA_WIDTH];
        rom_im_d = RomIm[r_d*DATA_WIDTH +: DATA_WIDTH];
    end

    // Stage 2: quadrant map; outputs hold their last values across invalid slots
    always_comb begin
        qd     = e_q[Log2N-1 -: 2];
        map_re = rom_re_q;
        map_im = rom_im_q;
        unique case (qd)
            2'd0: begin map_re = rom_re_q;  map_im = rom_im_q;  end
            2'd1: begin map_re = rom_im_q;  map_im = -rom_re_q; end
            2'd2: begin map_re = -rom_re_q; map_im = -rom_im_q; end
            2'd3: begin map_re = -rom_im_q; map_im = rom_re_q;  end
        endcase
        tw_real_d    = tw_real_q;
        tw_imag_d    = tw_imag_q;
        tw_exp_d     = tw_exp_q;
        tw_trivial_d = tw_trivial_q;
        out_valid_d  = v1_q;
        frame_done_d = v1_q & last1_q;
        if (v1_q) begin
            tw_real_d    = map_re;
            tw_imag_d    = map_im;
            tw_exp_d     = e_q;
            tw_trivial_d = (e_q[RBits-1:0] == '0);
        end
    end

    // All state; asynchronous reset drops in-flight samples and restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q          <= '0;
            e_q          <= '0;
            v1_q         <= 1'b0;
            last1_q      <= 1'b0;
            rom_re_q     <= '0;
            rom_im_q     <= '0;
            tw_real_q    <= '0;
            tw_imag_q    <= '0;
            tw_exp_q     <= '0;
            tw_trivial_q <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            c_q          <= c_d;
            e_q          <= e_d;
            v1_q         <= v1_d;
            last1_q      <= last1_d;
            rom_re_q     <= rom_re_d;
            rom_im_q     <= rom_im_d;
            tw_real_q    <= tw_real_d;
            tw_imag_q    <= tw_imag_d;
            tw_exp_q     <= tw_exp_d;
            tw_trivial_q <= tw_trivial_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tw_if.tw_real    = tw_real_q;
    assign tw_if.tw_imag    = tw_imag_q;
    assign tw_if.tw_exp     = tw_exp_q;
    assign tw_if.tw_trivial = tw_trivial_q;
    assign tw_if.out_valid  = out_valid_q;
    assign tw_if.frame_done = frame_done_q;

endmodule

// File: tb/tb_twiddle_gen_sdf.sv
// Bench for twiddle_gen_sdf at NFFT=64: one instance per legal (MODE, STAGE) pair, all driven
// with the same sample stream. Instances 0..5 are radix-2 stages 0..5, 6..8 radix-2^2 pairs 0..2.
module tb_twiddle_gen_sdf;
    localparam int  NI = 9;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic frame_start;

    always #5 clk = ~clk;

    logic [5:0]         exp_o  [NI];
    logic signed [14:0] re_o   [NI];
    logic signed [14:0] im_o   [NI];
    logic               triv_o [NI];
    logic               ov_o   [NI];
    logic               fd_o   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int M = (g < 6) ? 0 : 1;
        localparam int S = (g < 6) ? g : g - 6;

        twiddle_gen_sdf_if #(.DATA_WIDTH(15), .EXP_WIDTH(6)) bus ();

        assign bus.in_valid    = in_valid;
        assign bus.frame_start = frame_start;

        twiddle_gen_sdf #(
            .NFFT      (64),
            .DATA_WIDTH(15),
            .FRAC_BITS (10),
            .STAGE     (S),
            .MODE      (M)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .tw_if(bus)
        );

        assign exp_o[g]  = bus.tw_exp;
        assign re_o[g]   = bus.tw_real;
        assign im_o[g]   = bus.tw_imag;
        assign triv_o[g] = bus.tw_trivial;
        assign ov_o[g]   = bus.out_valid;
        assign fd_o[g]   = bus.frame_done;
    end

    int nvec = 0;
    int nerr = 0;
    int c_m;
    int fd_count;
    bit p1_v, p2_v;
    int p1_ci, p2_ci;
    int hexp [NI];
    int hre  [NI];
    int him  [NI];
    int htriv[NI];

    task automatic chk(input string tag, input logic signed [31:0] got, input int expv);
        nvec++;
        assert (got === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    // Exponent straight from the block-size definitions, in integer arithmetic.
    function automatic int model_exp(input int i, input int ci);
        int l, n1, q, br, p;
        if (i < 6) begin
            l = 64 >> i;
            if ((ci % l) >= l / 2) return ((ci % (l / 2)) * (1 << i)) % 64;
            return 0;
        end
        p  = i - 6;
        l  = 64 >> (2 * p);
        n1 = ci % (l / 4);
        q  = (ci % l) / (l / 4);
        br = (q == 1) ? 2 : (q == 2) ? 1 : q;
        return (n1 * br * (4 ** p)) % 64;
    endfunction

    function automatic int model_re(input int e);
        return rnd(1024.0 * $cos(2.0 * PI * real'(e) / 64.0));
    endfunction

    function automatic int model_im(input int e);
        return rnd(-1024.0 * $sin(2.0 * PI * real'(e) / 64.0));
    endfunction

    task automatic model_reset();
        c_m  = 0;
        p1_v = 1'b0;
        p2_v = 1'b0;
        p1_ci = 0;
        p2_ci = 0;
        for (int i = 0; i < NI; i++) begin
            hexp[i] = 0; hre[i] = 0; him[i] = 0; htriv[i] = 0;
        end
    endtask

    // Compare every instance against the held model outputs for the sample now on display.
    task automatic score();
        int e;
        for (int i = 0; i < NI; i++) begin
            if (p2_v) begin
                e        = model_exp(i, p2_ci);
                hexp[i]  = e;
                hre[i]   = model_re(e);
                him[i]   = model_im(e);
                htriv[i] = (e % 16 == 0) ? 1 : 0;
            end
            chk($sformatf("i%0d c%0d out_valid", i, p2_ci), ov_o[i], int'(p2_v));
            chk($sformatf("i%0d c%0d frame_done", i, p2_ci), fd_o[i],
                (p2_v && p2_ci == 63) ? 1 : 0);
            chk($sformatf("i%0d c%0d tw_exp", i, p2_ci), exp_o[i], hexp[i]);
            chk($sformatf("i%0d c%0d tw_real", i, p2_ci), re_o[i], hre[i]);
            chk($sformatf("i%0d c%0d tw_imag", i, p2_ci), im_o[i], him[i]);
            chk($sformatf("i%0d c%0d tw_trivial", i, p2_ci), triv_o[i], htriv[i]);
        end
    endtask

    // Hand-computed points (C[4]=946, S[4]=-392, C[8]=724, S[8]=-724, C[13]=297, S[13]=-980).
    task automatic directed();
        if (p2_v) begin
            case (p2_ci)
                5: begin
                    chk("r2s0 c5 re", re_o[0], 1024);
                    chk("r2s0 c5 im", im_o[0], 0);
                    chk("r2s0 c5 trivial", triv_o[0], 1);
                end
                17: chk("r22p0 c17 exp", exp_o[6], 2);
                36: begin
                    chk("r2s0 c36 re", re_o[0], 946);
                    chk("r2s0 c36 im", im_o[0], -392);
                end
                40: begin
                    chk("r2s0 c40 exp", exp_o[0], 8);
                    chk("r2s0 c40 re", re_o[0], 724);
                    chk("r2s0 c40 im", im_o[0], -724);
                    chk("r2s0 c40 trivial", triv_o[0], 0);
                end
                48: begin
                    chk("r2s0 c48 exp", exp_o[0], 16);
                    chk("r2s0 c48 re", re_o[0], 0);
                    chk("r2s0 c48 im", im_o[0], -1024);
                    chk("r2s0 c48 trivial", triv_o[0], 1);
                end
                50: chk("r22p0 c50 exp", exp_o[6], 6);
                60: begin
                    chk("r22p0 c60 exp", exp_o[6], 36);
                    chk("r22p0 c60 re", re_o[6], -946);
                    chk("r22p0 c60 im", im_o[6], 392);
                end
                62: chk("r2s0 c62 frame_done", fd_o[0], 0);
                63: begin
                    chk("r2s0 c63 frame_done", fd_o[0], 1);
                    chk("r22p0 c63 exp", exp_o[6], 45);
                    chk("r22p0 c63 re", re_o[6], -297);
                    chk("r22p0 c63 im", im_o[6], 980);
                end
                default: ;
            endcase
        end
    endtask

    // One clock: drive, let the edge pass, advance the model and check.
    task automatic cyc(input bit v, input bit fs);
        int ci;
        in_valid    = v;
        frame_start = fs;
        @(posedge clk);
        #1;
        ci    = fs ? 0 : c_m;
        p2_v  = p1_v;
        p2_ci = p1_ci;
        p1_v  = v;
        p1_ci = ci;
        if (v) c_m = (ci + 1) % 64;
        if (fd_o[0] === 1'b1) fd_count++;
        score();
        directed();
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        fd_count    = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        score();
        rst_n = 1'b1;

        // Reset in the middle of a frame at c=37
        cyc(1'b1, 1'b1);
        repeat (36) cyc(1'b1, 1'b0);
        chk("pre-reset r2s0 exp", exp_o[0], 3);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async reset exp", exp_o[0], 0);
        chk("async reset out_valid", ov_o[0], 0);
        score();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("post-reset out_valid early", ov_o[0], 0);
        cyc(1'b0, 1'b0);
        chk("post-reset out_valid", ov_o[0], 1);
        chk("post-reset exp r2", exp_o[0], 0);
        chk("post-reset exp r22", exp_o[6], 0);
        cyc(1'b0, 1'b0);

        // Full back-to-back frame
        cyc(1'b1, 1'b1);
        repeat (63) cyc(1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0);

        // Valid gaps 1,0,0,1 at c=40; frame_start in a gap is ignored
        cyc(1'b1, 1'b1);
        repeat (39) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("gap seq ov0", ov_o[0], 1);
        cyc(1'b0, 1'b1);
        chk("gap seq ov1", ov_o[0], 1);
        chk("gap seq exp1", exp_o[0], 8);
        cyc(1'b0, 1'b0);
        chk("gap seq ov2", ov_o[0], 0);
        chk("gap hold exp2", exp_o[0], 8);
        cyc(1'b1, 1'b0);
        chk("gap seq ov3", ov_o[0], 0);
        chk("gap hold re3", re_o[0], 724);
        cyc(1'b0, 1'b0);
        chk("gap seq ov4", ov_o[0], 1);
        chk("gap c41 exp r2", exp_o[0], 9);
        chk("gap c41 exp r22", exp_o[6], 9);
        cyc(1'b0, 1'b0);

        // frame_start at c=20 restarts the frame
        fd_count = 0;
        cyc(1'b1, 1'b1);
        repeat (19) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        chk("restart sample r22 exp", exp_o[6], 0);
        repeat (62) cyc(1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0);
        chk("restart frame_done count", fd_count, 1);

        // Two frames from a single frame_start
        fd_count = 0;
        cyc(1'b1, 1'b1);
        repeat (127) cyc(1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0);
        chk("two-frame frame_done count", fd_count, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
